// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared encodings and opcodes for the LCD bus decoder
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_INIT8   = 2'd0,
    ST_PAIR_HI = 2'd1,
    ST_PAIR_LO = 2'd2
  } lcd_state_e;

  localparam int ERR_SHORT_E = 0;
  localparam int ERR_BUS_CHG = 1;
  localparam int ERR_RW      = 2;
  localparam int ERR_PAIR    = 3;

  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_HOME      = 8'h02;
  localparam logic [7:0] CMD_SET_DDRAM = 8'h80;

  // Cursor address after the controller has executed byte b
  function automatic logic [6:0] next_ddram_addr(input logic [6:0] addr,
                                                 input logic [7:0] b,
                                                 input logic       rs);
    if (rs)
      return addr + 7'd1;
    else if (b == CMD_CLEAR || b[7:1] == CMD_HOME[7:1])
      return 7'd0;
    else if ((b & CMD_SET_DDRAM) != 8'h00)
      return b[6:0];
    else
      return addr;
  endfunction

endpackage

// File: rtl/lcd_e_sampler.sv
// rtl/lcd_e_sampler.sv - two-stage bus sampler, E falling-edge detect and timing checks
module lcd_e_sampler
  import lcd_pkg::*;
#(
  parameter int E_MIN_HIGH = 12,
  parameter int CNT_W      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] i_sf_d,
  input  logic       i_sf_ceo,
  input  logic       i_lcd_e,
  input  logic       i_lcd_rs,
  input  logic       i_lcd_rw,
  output logic       o_fall,
  output logic       o_nib_valid,
  output logic [3:0] o_nib,
  output logic       o_nib_rs,
  output logic       o_err_short,
  output logic       o_err_chg,
  output logic       o_err_rw
);

  logic             r_s1_e, r_s1_ceo, r_s1_rs, r_s1_rw;
  logic [3:0]       r_s1_d;
  logic             r_s2_e, r_s2_rs, r_s2_rw;
  logic [3:0]       r_s2_d;
  logic [CNT_W-1:0] r_e_cnt;

  logic w_fall, w_short, w_rw, w_chg;

  // Pin synchronisers plus E-high width counter (saturating, cleared while E low or bus not owned)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_e   <= 1'b0;
      r_s1_ceo <= 1'b0;
      r_s1_rs  <= 1'b0;
      r_s1_rw  <= 1'b0;
      r_s1_d   <= 4'h0;
      r_s2_e   <= 1'b0;
      r_s2_rs  <= 1'b0;
      r_s2_rw  <= 1'b0;
      r_s2_d   <= 4'h0;
      r_e_cnt  <= '0;
    end else begin
      r_s1_e   <= i_lcd_e;
      r_s1_ceo <= i_sf_ceo;
      r_s1_rs  <= i_lcd_rs;
      r_s1_rw  <= i_lcd_rw;
      r_s1_d   <= i_sf_d;
      r_s2_e   <= r_s1_e;
      r_s2_rs  <= r_s1_rs;
      r_s2_rw  <= r_s1_rw;
      r_s2_d   <= r_s1_d;
      if (r_s1_e && r_s1_ceo) begin
        if (r_e_cnt != '1)
          r_e_cnt <= r_e_cnt + CNT_W'(1);
      end else begin
        r_e_cnt <= '0;
      end
    end
  end

  assign w_fall  = r_s2_e & ~r_s1_e & r_s1_ceo;
  assign w_short = w_fall & (r_e_cnt < CNT_W'(E_MIN_HIGH));
  assign w_rw    = w_fall & r_s2_rw;
  assign w_chg   = r_s1_ceo & r_s1_e & r_s2_e &
                   ((r_s1_d != r_s2_d) | (r_s1_rs != r_s2_rs));

  assign o_fall      = w_fall;
  assign o_nib_valid = w_fall & ~w_short & ~w_rw;
  assign o_nib       = r_s2_d;
  assign o_nib_rs    = r_s2_rs;
  assign o_err_short = w_short;
  assign o_err_chg   = w_chg;
  assign o_err_rw    = w_rw;

endmodule

// File: rtl/lcd_bus_decoder.sv
// rtl/lcd_bus_decoder.sv - LCD 4-bit write-bus decoder; LCD_DECODE_ADDR_EN enables DDRAM address tracking
module lcd_bus_decoder
  import lcd_pkg::*;
#(
  parameter int E_MIN_HIGH   = 12,
  parameter int PAIR_TIMEOUT = 50000,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sf_d,
  input  logic       sf_ceo,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_rs,
  output logic       byte_init,
  output logic       err_pulse,
  output logic [3:0] err_status,
  output logic [6:0] ddram_addr
);

  logic       w_fall, w_nib_valid, w_nib_rs;
  logic [3:0] w_nib;
  logic       w_err_short, w_err_chg, w_err_rw;

  lcd_e_sampler #(
    .E_MIN_HIGH (E_MIN_HIGH),
    .CNT_W      (CNT_W)
  ) u_sampler (
    .clk         (clk),
    .reset       (reset),
    .i_sf_d      (sf_d),
    .i_sf_ceo    (sf_ceo),
    .i_lcd_e     (lcd_e),
    .i_lcd_rs    (lcd_rs),
    .i_lcd_rw    (lcd_rw),
    .o_fall      (w_fall),
    .o_nib_valid (w_nib_valid),
    .o_nib       (w_nib),
    .o_nib_rs    (w_nib_rs),
    .o_err_short (w_err_short),
    .o_err_chg   (w_err_chg),
    .o_err_rw    (w_err_rw)
  );

  lcd_state_e       r_state, w_state;
  logic [3:0]       r_hi, w_hi;
  logic             r_hi_rs, w_hi_rs;
  logic [CNT_W-1:0] r_pair_cnt, w_pair_cnt;
  logic             r_byte_valid, w_byte_valid;
  logic [7:0]       r_byte_data, w_byte_data;
  logic             r_byte_rs, w_byte_rs;
  logic             r_byte_init, w_byte_init;
  logic             r_err_pulse;
  logic [3:0]       r_err_status;
  logic [3:0]       w_err;

  // State and output registers; a reset drops any held high nibble
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_INIT8;
      r_hi         <= 4'h0;
      r_hi_rs      <= 1'b0;
      r_pair_cnt   <= '0;
      r_byte_valid <= 1'b0;
      r_byte_data  <= 8'h00;
      r_byte_rs    <= 1'b0;
      r_byte_init  <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_err_status <= 4'h0;
    end else begin
      r_state      <= w_state;
      r_hi         <= w_hi;
      r_hi_rs      <= w_hi_rs;
      r_pair_cnt   <= w_pair_cnt;
      r_byte_valid <= w_byte_valid;
      r_byte_data  <= w_byte_data;
      r_byte_rs    <= w_byte_rs;
      r_byte_init  <= w_byte_init;
      r_err_pulse  <= |w_err;
      r_err_status <= r_err_status | w_err;
    end
  end

  // Nibble pairing: init nibbles stand alone, then hi/lo pairs with rs match and timeout
  always_comb begin
    w_state      = r_state;
    w_hi         = r_hi;
    w_hi_rs      = r_hi_rs;
    w_pair_cnt   = r_pair_cnt;
    w_byte_valid = 1'b0;
    w_byte_data  = r_byte_data;
    w_byte_rs    = r_byte_rs;
    w_byte_init  = r_byte_init;
    w_err                = 4'h0;
    w_err[ERR_SHORT_E]   = w_err_short;
    w_err[ERR_BUS_CHG]   = w_err_chg;
    w_err[ERR_RW]        = w_err_rw;

    case (r_state)
      ST_INIT8: begin
        if (w_nib_valid) begin
          w_byte_valid = 1'b1;
          w_byte_data  = {w_nib, 4'h0};
          w_byte_rs    = w_nib_rs;
          w_byte_init  = 1'b1;
          // 0x2 as a command switches the controller into 4-bit mode
          if (w_nib == 4'h2 && !w_nib_rs)
            w_state = ST_PAIR_HI;
        end
      end
      ST_PAIR_HI: begin
        if (w_nib_valid) begin
          w_hi       = w_nib;
          w_hi_rs    = w_nib_rs;
          w_pair_cnt = '0;
          w_state    = ST_PAIR_LO;
        end
      end
      ST_PAIR_LO: begin
        if (w_nib_valid) begin
          if (w_nib_rs == r_hi_rs) begin
            w_byte_valid = 1'b1;
            w_byte_data  = {r_hi, w_nib};
            w_byte_rs    = r_hi_rs;
            w_byte_init  = 1'b0;
            w_state      = ST_PAIR_HI;
          end else begin
            // Resynchronise on the new nibble rather than losing it
            w_err[ERR_PAIR] = 1'b1;
            w_hi            = w_nib;
            w_hi_rs         = w_nib_rs;
            w_pair_cnt      = '0;
          end
        end else if (!w_fall) begin
          // Any falling edge this cycle takes priority over the timeout
          if (r_pair_cnt >= CNT_W'(PAIR_TIMEOUT)) begin
            w_err[ERR_PAIR] = 1'b1;
            w_state         = ST_PAIR_HI;
          end else begin
            w_pair_cnt = r_pair_cnt + CNT_W'(1);
          end
        end
      end
      default: w_state = ST_INIT8;
    endcase
  end

  assign byte_valid = r_byte_valid;
  assign byte_data  = r_byte_data;
  assign byte_rs    = r_byte_rs;
  assign byte_init  = r_byte_init;
  assign err_pulse  = r_err_pulse;
  assign err_status = r_err_status;

`ifdef LCD_DECODE_ADDR_EN
  logic [6:0] r_ddram_addr;

  // Follow the controller cursor from each published byte
  always_ff @(posedge clk) begin
    if (reset)
      r_ddram_addr <= 7'd0;
    else if (r_byte_valid)
      r_ddram_addr <= next_ddram_addr(r_ddram_addr, r_byte_data, r_byte_rs);
  end

  assign ddram_addr = r_ddram_addr;
`else
  assign ddram_addr = 7'd0;
`endif

endmodule
